alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the single-cycle `alu`. It executes every base ALU operation with a one-cycle registered result. It adds iterative multiply, divide and remainder (RISC-V M semantics) at one bit per cycle. It sits between the decode/issue stage and writeback; the `valid`/`ready` pair on each side lets the pipeline stall on long operations.

## Interface
Parameters
- `C_WIDTH`, 32: operand and result width; must be ≥ 4 and a power of two.
- `SHW`, `$clog2(C_WIDTH)`: shift-amount width. Derived; never overridden.

Ports (one clock; reset is synchronous and active-high)
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and opcode are valid.
- `in_ready`  out  1  block can accept an operation.
- `A`  in  C_WIDTH  operand A (rs1).
- `B`  in  C_WIDTH  operand B (rs2).
- `opcode`  in  5  `[4]`=0: base op in `[3:0]` (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0111, SLL 1000, SRL 1001, SRA 1011). `[4]`=1: M op (MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111).
- `out_valid`  out  1  `Result`, `Status` and `out_err` are valid.
- `out_ready`  in  1  consumer takes the result.
- `Result`  out  C_WIDTH  registered result.
- `Status`  out  4  registered flags {N,Z,C,V}.
- `out_err`  out  1  the opcode was undefined.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - BUSY: M-op iteration in progress.
  - DONE: `out_valid`=1.
- IDLE transitions, taken when `in_valid`:
  - Base or undefined op: result is computed combinationally, registered, and the FSM goes to DONE.
  - M op: operands and opcode are latched, the iteration counter is set to C_WIDTH, and the FSM goes to BUSY.
- Early-out M ops go straight from IDLE to DONE:
  - DIV/DIVU with B=0: quotient all ones.
  - REM/REMU with B=0: result = A.
  - DIV with A=MIN, B=−1: quotient MIN. REM with the same operands: 0.
- BUSY:
  - Multiply: shift-add on operand magnitudes, with signs fixed up at the end.
  - Divide: restoring, one quotient bit per cycle on magnitudes. Quotient sign = sign(A) xor sign(B); remainder takes the sign of A.
  - The counter decrements each cycle. At 0 the result is written and the FSM goes to DONE.
- Result selection: MUL gives the low C_WIDTH bits. MULH, MULHSU and MULHU give the high C_WIDTH bits of the 2·C_WIDTH-bit product.
- DONE: outputs hold stable until `out_ready`=1, then the FSM goes to IDLE. No new operation is accepted in the same cycle.
- Shifts use `B[SHW-1:0]` only; the upper bits of B are ignored.
- Flags:
  - Base ops: identical to `alu`. C and V are meaningful only for ADD/SUB and are 0 otherwise.
  - M ops: N = Result MSB, Z = (Result==0), C = V = 0.
- Undefined opcode: Result=0, Status=4'b0100, `out_err`=1. The op still completes through DONE.
- Reset (any state, including mid-BUSY): FSM→IDLE, `out_valid`=0, `Result`=0, `Status`=0, `out_err`=0, counter=0. Any in-flight operation is discarded.

## Timing
- `in_ready` = (state==IDLE). It is a registered-state decode with no combinational path from `out_ready`.
- Base op accepted in cycle t → `out_valid` at t+1.
- Iterative M op accepted at t → `out_valid` at t+C_WIDTH+1.
- Early-out M op accepted at t → `out_valid` at t+1.
- Back-to-back throughput for base ops: one op every 2 cycles (DONE→IDLE costs one cycle).
- If `out_ready` is held 0, the result holds indefinitely; `in_ready` stays 0.

## Structure
- `alu_pkg`:
  - opcode localparams for all 18 codes;
  - FSM state enum {IDLE, BUSY, DONE};
  - Status bit index constants N=3, Z=2, C=1, V=0.
- Instantiate the existing combinational `alu` (C_WIDTH passed through) for base ops.
- Put the iterative engine in one sub-module, `alu_muldiv`: start pulse, operands and op in; done pulse and result out; C_WIDTH-cycle counter inside.
- The top level holds the FSM, output registers and handshake.

## Test plan
All scenarios run with C_WIDTH=8.
- ADD A=0x7F, B=0x01 → 1 cycle later: Result=0x80, Status=4'b1001. Then SUB A=0x00, B=0x01 → Result=0xFF, Status=4'b1010.
- MUL A=0xFD (−3), B=0x05 → `out_valid` exactly 9 cycles after accept, Result=0xF1. MULH with the same operands → 0xFF. MULHU → 0x04.
- DIV A=0xF9 (−7), B=0x02 → Result=0xFD, Status=4'b1000. REM → Result=0xFF. DIVU A=0x07, B=0x00 → Result=0xFF after 1 cycle. DIV A=0x80, B=0xFF → 0x80.
- Backpressure: hold `out_ready`=0 for 5 cycles after a MULHU → Result, Status and `out_valid` stable, `in_ready`=0. Release → IDLE next cycle.
- Assert `rst` on the 4th BUSY cycle of a DIVU → next cycle: IDLE, `out_valid`=0, Result=0. A following ADD 2+3 returns 5.
- Opcode 5'b00110 → Result=0, Status=4'b0100, `out_err`=1. SLL A=0x01, B=0x0B → 0x08 (only B[2:0]=3 is used).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and status-flag layout for the sequential ALU.
// Imported by the base ALU, the iterative mul/div engine and the top level.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00010;
    localparam logic [4:0] OP_OR     = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SLT    = 5'b00101;
    localparam logic [4:0] OP_SLTU   = 5'b00111;
    localparam logic [4:0] OP_SLL    = 5'b01000;
    localparam logic [4:0] OP_SRL    = 5'b01001;
    localparam logic [4:0] OP_SRA    = 5'b01011;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] STATUS_UNDEF = 4'b0100;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU for the base (non-M) operations with {N,Z,C,V} flags.
// C is the carry-out for ADD and the borrow for SUB; C and V are 0 for every other op.
module alu
    import alu_pkg::*;
#(
    parameter int C_WIDTH = 32
) (
    input  logic [C_WIDTH-1:0] a_i,
    input  logic [C_WIDTH-1:0] b_i,
    input  logic [4:0]         op_i,
    output logic [C_WIDTH-1:0] result_o,
    output logic [3:0]         status_o,
    output logic               err_o
);

    localparam int SHW = $clog2(C_WIDTH);

    logic [C_WIDTH:0] sum;
    logic [C_WIDTH:0] diff;
    logic [SHW-1:0]   shamt;
    logic             carry;
    logic             ovf;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        diff     = {1'b0, a_i} - {1'b0, b_i};
        shamt    = b_i[SHW-1:0];
        result_o = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        err_o    = 1'b0;

        case (op_i)
            OP_ADD: begin
                result_o = sum[C_WIDTH-1:0];
                carry    = sum[C_WIDTH];
                ovf      = (a_i[C_WIDTH-1] == b_i[C_WIDTH-1]) &&
                           (result_o[C_WIDTH-1] != a_i[C_WIDTH-1]);
            end
            OP_SUB: begin
                result_o = diff[C_WIDTH-1:0];
                carry    = diff[C_WIDTH];
                ovf      = (a_i[C_WIDTH-1] != b_i[C_WIDTH-1]) &&
                           (result_o[C_WIDTH-1] != a_i[C_WIDTH-1]);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SLT:  result_o = {{(C_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: result_o = {{(C_WIDTH-1){1'b0}}, (a_i < b_i)};
            OP_SLL:  result_o = a_i << shamt;
            OP_SRL:  result_o = a_i >> shamt;
            OP_SRA:  result_o = $signed(a_i) >>> shamt;
            default: err_o    = 1'b1;
        endcase

        status_o = '0;
        if (err_o) begin
            status_o = STATUS_UNDEF;
        end else begin
            status_o[FLAG_N] = result_o[C_WIDTH-1];
            status_o[FLAG_Z] = (result_o == '0);
            status_o[FLAG_C] = carry;
            status_o[FLAG_V] = ovf;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply / divide engine, one bit per cycle on operand magnitudes.
// A start pulse loads operands; done_o pulses in the last iteration cycle with result_o valid.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int C_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [C_WIDTH-1:0] a_i,
    input  logic [C_WIDTH-1:0] b_i,
    input  logic [4:0]         op_i,
    output logic               done_o,
    output logic [C_WIDTH-1:0] result_o
);

    localparam int CW = $clog2(C_WIDTH) + 1;

    // hi holds the running partial product / partial remainder, lo the multiplier / quotient.
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [C_WIDTH:0]   hi_q, hi_d;
    logic [C_WIDTH-1:0] lo_q, lo_d;
    logic [C_WIDTH-1:0] opnd_q, opnd_d;
    logic [4:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               nega_q, nega_d;

    logic               a_sgn, b_sgn;
    logic [C_WIDTH-1:0] abs_a, abs_b;
    logic [C_WIDTH:0]   shifted;
    logic [C_WIDTH:0]   addend;
    logic [C_WIDTH:0]   sum;

    logic [2*C_WIDTH-1:0] prod_mag, prod;
    logic [C_WIDTH-1:0]   quo, rem;

    always_comb begin
        a_sgn = ((op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                 (op_i == OP_DIV) || (op_i == OP_REM)) && a_i[C_WIDTH-1];
        b_sgn = ((op_i == OP_MUL) || (op_i == OP_MULH) ||
                 (op_i == OP_DIV) || (op_i == OP_REM)) && b_i[C_WIDTH-1];
        abs_a = a_sgn ? -a_i : a_i;
        abs_b = b_sgn ? -b_i : b_i;

        shifted = {hi_q[C_WIDTH-1:0], lo_q[C_WIDTH-1]};
        addend  = lo_q[0] ? {1'b0, opnd_q} : '0;
        sum     = hi_q + addend;

        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        op_d   = op_q;
        neg_d  = neg_q;
        nega_d = nega_q;

        if (start_i) begin
            cnt_d  = CW'(C_WIDTH);
            hi_d   = '0;
            op_d   = op_i;
            neg_d  = a_sgn ^ b_sgn;
            nega_d = a_sgn;
            if (op_i[2]) begin
                lo_d   = abs_a;
                opnd_d = abs_b;
            end else begin
                lo_d   = abs_b;
                opnd_d = abs_a;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (op_q[2]) begin
                // Restoring step: keep the trial subtraction only when it does not borrow.
                if (shifted >= {1'b0, opnd_q}) begin
                    hi_d = shifted - {1'b0, opnd_q};
                    lo_d = {lo_q[C_WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shifted;
                    lo_d = {lo_q[C_WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_d = {1'b0, sum[C_WIDTH:1]};
                lo_d = {sum[0], lo_q[C_WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        prod_mag = {hi_d[C_WIDTH-1:0], lo_d};
        prod     = neg_q ? -prod_mag : prod_mag;
        quo      = neg_q ? -lo_d : lo_d;
        rem      = nega_q ? -hi_d[C_WIDTH-1:0] : hi_d[C_WIDTH-1:0];

        case (op_q)
            OP_MUL:                        result_o = prod[C_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result_o = prod[2*C_WIDTH-1:C_WIDTH];
            OP_DIV, OP_DIVU:               result_o = quo;
            OP_REM, OP_REMU:               result_o = rem;
            default:                       result_o = '0;
        endcase
    end

    assign done_o = (cnt_q == CW'(1));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            nega_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            op_q   <= op_d;
            neg_q  <= neg_d;
            nega_q <= nega_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: registered base ops in one cycle, iterative RISC-V M ops.
// Holds the IDLE/BUSY/DONE FSM, the output registers and the valid/ready handshake.
module alu_seq
    import alu_pkg::*;
#(
    parameter int C_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [C_WIDTH-1:0] A,
    input  logic [C_WIDTH-1:0] B,
    input  logic [4:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [C_WIDTH-1:0] Result,
    output logic [3:0]         Status,
    output logic               out_err
);

    localparam logic [C_WIDTH-1:0] MIN_VAL = {1'b1, {(C_WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [C_WIDTH-1:0] result_q, result_d;
    logic [3:0]         status_q, status_d;
    logic               err_q, err_d;

    logic [C_WIDTH-1:0] alu_result;
    logic [3:0]         alu_status;
    logic               alu_err;

    logic               mdu_start;
    logic               mdu_done;
    logic [C_WIDTH-1:0] mdu_result;

    logic               early;
    logic [C_WIDTH-1:0] early_result;
    logic               b_zero;
    logic               div_ovf;

    function automatic logic [3:0] m_flags(input logic [C_WIDTH-1:0] r);
        m_flags         = '0;
        m_flags[FLAG_N] = r[C_WIDTH-1];
        m_flags[FLAG_Z] = (r == '0);
    endfunction

    alu #(.C_WIDTH(C_WIDTH)) u_alu (
        .a_i      (A),
        .b_i      (B),
        .op_i     (opcode),
        .result_o (alu_result),
        .status_o (alu_status),
        .err_o    (alu_err)
    );

    alu_muldiv #(.C_WIDTH(C_WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mdu_start),
        .a_i      (A),
        .b_i      (B),
        .op_i     (opcode),
        .done_o   (mdu_done),
        .result_o (mdu_result)
    );

    // Division by zero and signed MIN / -1 finish without iterating.
    always_comb begin
        b_zero       = (B == '0);
        div_ovf      = (A == MIN_VAL) && (&B);
        early        = 1'b0;
        early_result = '0;
        case (opcode)
            OP_DIV: begin
                early        = b_zero || div_ovf;
                early_result = b_zero ? '1 : MIN_VAL;
            end
            OP_DIVU: begin
                early        = b_zero;
                early_result = '1;
            end
            OP_REM: begin
                early        = b_zero || div_ovf;
                early_result = b_zero ? A : '0;
            end
            OP_REMU: begin
                early        = b_zero;
                early_result = A;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        status_d  = status_q;
        err_d     = err_q;
        mdu_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DONE;
                    if (!opcode[4]) begin
                        result_d = alu_result;
                        status_d = alu_status;
                        err_d    = alu_err;
                    end else if (opcode[3]) begin
                        result_d = '0;
                        status_d = STATUS_UNDEF;
                        err_d    = 1'b1;
                    end else if (early) begin
                        result_d = early_result;
                        status_d = m_flags(early_result);
                        err_d    = 1'b0;
                    end else begin
                        mdu_start = 1'b1;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mdu_done) begin
                    result_d = mdu_result;
                    status_d = m_flags(mdu_result);
                    err_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            status_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            status_q <= status_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Result    = result_q;
    assign Status    = status_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at C_WIDTH=8 with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [4:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Result;
    logic [3:0] Status;
    logic       out_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq #(.C_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Status    (Status),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents one op for exactly one accepting edge.
    task automatic issue(input string tag, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        opcode   = op;
        A        = a;
        B        = b;
        tick();
        in_valid = 1'b0;
    endtask

    // Latency = number of edges from the accepting edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " idle after release"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_res, input logic [3:0] exp_st,
                          input logic exp_err, input int exp_lat);
        int lat;
        issue(tag, op, a, b);
        wait_valid(lat);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, 32'(Result), 32'(exp_res));
        check({tag, " status"}, 32'(Status), 32'(exp_st));
        check({tag, " err"}, 32'(out_err), 32'(exp_err));
        release_out(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic seen_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        opcode    = '0;
        tick();
        tick();
        check("reset result", 32'(Result), 32'h0);
        check("reset status", 32'(Status), 32'h0);
        check("reset err", 32'(out_err), 32'h0);
        check("reset handshake", {30'd0, in_ready, out_valid}, 32'b10);
        rst = 1'b0;
        tick();

        // Base ops: one-cycle latency, ADD/SUB flags including overflow and borrow.
        run_op("add 7f+1", OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1001, 1'b0, 1);
        run_op("sub 0-1", OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b1010, 1'b0, 1);
        run_op("add ff+1", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0, 1);
        run_op("and", OP_AND, 8'hF0, 8'h0F, 8'h00, 4'b0100, 1'b0, 1);
        run_op("or", OP_OR, 8'hA0, 8'h05, 8'hA5, 4'b1000, 1'b0, 1);
        run_op("xor", OP_XOR, 8'hF0, 8'hFF, 8'h0F, 4'b0000, 1'b0, 1);
        run_op("slt", OP_SLT, 8'hFF, 8'h01, 8'h01, 4'b0000, 1'b0, 1);
        run_op("sltu", OP_SLTU, 8'hFF, 8'h01, 8'h00, 4'b0100, 1'b0, 1);
        run_op("sra", OP_SRA, 8'h80, 8'h02, 8'hE0, 4'b1000, 1'b0, 1);
        run_op("srl", OP_SRL, 8'h80, 8'h02, 8'h20, 4'b0000, 1'b0, 1);
        run_op("sll b masked", OP_SLL, 8'h01, 8'h0B, 8'h08, 4'b0000, 1'b0, 1);

        // Iterative multiply: C_WIDTH+1 cycles.
        run_op("mul", OP_MUL, 8'hFD, 8'h05, 8'hF1, 4'b1000, 1'b0, 9);
        run_op("mulh", OP_MULH, 8'hFD, 8'h05, 8'hFF, 4'b1000, 1'b0, 9);
        run_op("mulhsu", OP_MULHSU, 8'hFD, 8'h05, 8'hFF, 4'b1000, 1'b0, 9);
        run_op("mul min*-1", OP_MUL, 8'h80, 8'hFF, 8'h80, 4'b1000, 1'b0, 9);

        // MULHU with backpressure: outputs hold and in_ready stays low.
        issue("mulhu", OP_MULHU, 8'hFD, 8'h05);
        wait_valid(lat);
        check("mulhu latency", lat, 9);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp result", 32'(Result), 32'h04);
            check("bp status", 32'(Status), 32'h0);
            check("bp handshake", {30'd0, in_ready, out_valid}, 32'b01);
        end
        release_out("mulhu");

        // Divide and remainder, iterative and early-out.
        run_op("div", OP_DIV, 8'hF9, 8'h02, 8'hFD, 4'b1000, 1'b0, 9);
        run_op("rem", OP_REM, 8'hF9, 8'h02, 8'hFF, 4'b1000, 1'b0, 9);
        run_op("divu", OP_DIVU, 8'hC8, 8'h07, 8'h1C, 4'b0000, 1'b0, 9);
        run_op("remu", OP_REMU, 8'hC8, 8'h07, 8'h04, 4'b0000, 1'b0, 9);
        run_op("divu by 0", OP_DIVU, 8'h07, 8'h00, 8'hFF, 4'b1000, 1'b0, 1);
        run_op("remu by 0", OP_REMU, 8'h07, 8'h00, 8'h07, 4'b0000, 1'b0, 1);
        run_op("div min/-1", OP_DIV, 8'h80, 8'hFF, 8'h80, 4'b1000, 1'b0, 1);
        run_op("rem min/-1", OP_REM, 8'h80, 8'hFF, 8'h00, 4'b0100, 1'b0, 1);

        // Reset during the 4th BUSY cycle of a DIVU discards the operation.
        issue("divu abort", OP_DIVU, 8'h64, 8'h07);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort handshake", {30'd0, in_ready, out_valid}, 32'b10);
        check("abort result", 32'(Result), 32'h0);
        check("abort status", 32'(Status), 32'h0);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen_valid = seen_valid | out_valid;
        end
        check("abort no late valid", 32'(seen_valid), 32'h0);
        run_op("add after abort", OP_ADD, 8'h02, 8'h03, 8'h05, 4'b0000, 1'b0, 1);

        // Undefined opcodes complete through DONE with the error flag.
        run_op("undef base", 5'b00110, 8'h12, 8'h34, 8'h00, 4'b0100, 1'b1, 1);
        run_op("undef m", 5'b11000, 8'h12, 8'h34, 8'h00, 4'b0100, 1'b1, 1);
        run_op("add clears err", OP_ADD, 8'h10, 8'h20, 8'h30, 4'b0000, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
